// File: rtl/uart_probe.sv
// Byte-command debug probe: a UART-side byte stream drives 32-bit GPIO and a
// single-outstanding AXI4-Lite-style master so a host can peek/poke a bus.
module uart_probe (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] gpo,
  input  logic [31:0] gpi,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arsize,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awsize,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  localparam logic [7:0] CMD_GPI_RD0 = 8'd2;
  localparam logic [7:0] CMD_GPI_RD3 = 8'd5;
  localparam logic [7:0] CMD_GPO_RD0 = 8'd6;
  localparam logic [7:0] CMD_GPO_RD3 = 8'd9;
  localparam logic [7:0] CMD_GPO_WR0 = 8'd10;
  localparam logic [7:0] CMD_GPO_WR3 = 8'd13;
  localparam logic [7:0] CMD_AXI_RD0 = 8'd14;
  localparam logic [7:0] CMD_AXI_RD3 = 8'd17;
  localparam logic [7:0] CMD_AXI_WR0 = 8'd18;
  localparam logic [7:0] CMD_AXI_WR3 = 8'd21;
  localparam logic [7:0] CMD_AXI_RD  = 8'd22;
  localparam logic [7:0] CMD_AXI_WR  = 8'd23;
  localparam logic [7:0] CMD_AXI_RDC = 8'd24;
  localparam logic [7:0] CMD_AXI_WRC = 8'd25;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_RESP, S_AR, S_R, S_AW_W, S_B
  } state_e;

  // The port name is historical; the reset is asserted high.
  logic rst;
  assign rst = m_aresetn;

  state_e      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] gpo_q, gpo_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic rx_ready_q, rx_ready_d;
  logic tx_valid_q, tx_valid_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;

  logic       rx_fire;
  logic [1:0] rx_lane;
  logic [1:0] cmd_lane;
  logic       unused_rdata_hi;

  assign rx_fire = rx_valid & rx_ready_q;
  // Every four-code group starts at a code that is 2 mod 4, so lane = code[1:0]-2.
  assign rx_lane  = rx_data[1:0] - 2'd2;
  assign cmd_lane = cmd_q[1:0] - 2'd2;
  assign unused_rdata_hi = ^m_axi_rdata[31:8];

  always_comb begin
    // NOTE: every _d takes its _q first, so no branch below can infer a latch.
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    gpo_d     = gpo_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    tx_data_d = tx_data_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          if (rx_data inside {[CMD_GPI_RD0:CMD_GPI_RD3]}) begin
            tx_data_d = gpi[{rx_lane, 3'b000} +: 8];
            state_d   = S_RESP;
          end else if (rx_data inside {[CMD_GPO_RD0:CMD_GPO_RD3]}) begin
            tx_data_d = gpo_q[{rx_lane, 3'b000} +: 8];
            state_d   = S_RESP;
          end else if (rx_data inside {[CMD_AXI_RD0:CMD_AXI_RD3]}) begin
            tx_data_d = addr_q[{rx_lane, 3'b000} +: 8];
            state_d   = S_RESP;
          end else if (rx_data == CMD_AXI_RD) begin
            tx_data_d = rdata_q;
            state_d   = S_RESP;
          end else if (rx_data == CMD_AXI_RDC) begin
            tx_data_d = {2'b00, bresp_q, rresp_q, 2'b00};
            state_d   = S_RESP;
          end else if (rx_data inside {[CMD_GPO_WR0:CMD_GPO_WR3],
                                       [CMD_AXI_WR0:CMD_AXI_WR3],
                                       CMD_AXI_WR, CMD_AXI_WRC}) begin
            cmd_d   = rx_data;
            state_d = S_ARG;
          end
        end
      end
      S_ARG: begin
        if (rx_fire) begin
          state_d = S_IDLE;
          if (cmd_q inside {[CMD_GPO_WR0:CMD_GPO_WR3]}) begin
            gpo_d[{cmd_lane, 3'b000} +: 8] = rx_data;
          end else if (cmd_q inside {[CMD_AXI_WR0:CMD_AXI_WR3]}) begin
            addr_d[{cmd_lane, 3'b000} +: 8] = rx_data;
          end else if (cmd_q == CMD_AXI_WR) begin
            wdata_d   = rx_data;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_AW_W;
          end else begin
            // Control byte: increment lands before the read so both bits chain.
            if (rx_data[1]) addr_d = addr_q + 32'd1;
            if (rx_data[0]) state_d = S_AR;
          end
        end
      end
      S_RESP: begin
        if (tx_valid_q && tx_ready) state_d = S_IDLE;
      end
      S_AR: begin
        if (arvalid_q && m_axi_arready) state_d = S_R;
      end
      S_R: begin
        if (rready_q && m_axi_rvalid) begin
          rdata_d = m_axi_rdata[7:0];
          rresp_d = m_axi_rresp;
          state_d = S_IDLE;
        end
      end
      S_AW_W: begin
        aw_done_d = aw_done_q | (awvalid_q & m_axi_awready);
        w_done_d  = w_done_q | (wvalid_q & m_axi_wready);
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (bready_q && m_axi_bvalid) begin
          bresp_d = m_axi_bresp;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of what the next state requires.
  always_comb begin
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ARG);
    tx_valid_d = (state_d == S_RESP);
    arvalid_d  = (state_d == S_AR);
    rready_d   = (state_d == S_R);
    awvalid_d  = (state_d == S_AW_W) && !aw_done_d;
    wvalid_d   = (state_d == S_AW_W) && !w_done_d;
    bready_d   = (state_d == S_B);
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'd0;
      addr_q     <= 32'd0;
      gpo_q      <= 32'd0;
      rdata_q    <= 8'd0;
      rresp_q    <= 2'd0;
      bresp_q    <= 2'd0;
      tx_data_q  <= 8'd0;
      wdata_q    <= 8'd0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      gpo_q      <= gpo_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      bresp_q    <= bresp_d;
      tx_data_q  <= tx_data_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
    end
  end

  assign rx_ready      = rx_ready_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign gpo           = gpo_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = {24'd0, wdata_q};
  assign m_axi_wstrb   = 4'b1111;
  assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_uart_probe.sv
// Scoreboard bench for uart_probe: a byte-level host model plus a randomized
// AXI slave; expected responses and bus transactions are queued and popped by monitors.
module tb_uart_probe;

  logic        clk = 1'b0;
  logic        m_aresetn = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [31:0] gpo;
  logic [31:0] gpi = 32'd0;
  logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_wdata;
  logic [2:0]  m_axi_arsize, m_axi_awsize;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  uart_probe dut (
    .clk(clk), .m_aresetn(m_aresetn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .gpo(gpo), .gpi(gpi),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_ar[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];

  // Reference model of the probe's architectural state
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_gpo = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  logic [1:0]  m_rresp = 2'd0;
  logic [1:0]  m_bresp = 2'd0;

  // Slave behaviour knobs
  logic [31:0] sl_rdata = 32'd0;
  logic [1:0]  sl_rresp = 2'd0;
  logic [1:0]  sl_bresp = 2'd0;
  int          sl_ar_delay = 0;

  // Host side: random backpressure on the response byte
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // AXI slave: decisions from negedge samples, drives applied just after posedge
  bit ar_hs, ar_v, r_hs, aw_hs, aw_v, w_hs, w_v, b_hs, aw_got, w_got;
  int ar_cnt;
  initial begin
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    ar_cnt = 0; aw_got = 0; w_got = 0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      ar_v  = m_axi_arvalid;
      r_hs  = m_axi_rvalid && m_axi_rready;
      aw_hs = m_axi_awvalid && m_axi_awready;
      aw_v  = m_axi_awvalid;
      w_hs  = m_axi_wvalid && m_axi_wready;
      w_v   = m_axi_wvalid;
      b_hs  = m_axi_bvalid && m_axi_bready;
      @(posedge clk); #1;
      if (m_aresetn) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
        m_axi_wready = 0; m_axi_bvalid = 0;
        ar_cnt = 0; aw_got = 0; w_got = 0;
      end else begin
        if (ar_hs) begin
          m_axi_arready = 0; ar_cnt = 0;
          m_axi_rvalid = 1; m_axi_rdata = sl_rdata; m_axi_rresp = sl_rresp;
        end else if (ar_v) begin
          if (ar_cnt >= sl_ar_delay) m_axi_arready = 1;
          else ar_cnt++;
        end else begin
          m_axi_arready = 0; ar_cnt = 0;
        end
        if (r_hs) m_axi_rvalid = 0;
        if (aw_hs) begin m_axi_awready = 0; aw_got = 1; end
        else if (aw_v) m_axi_awready = ($urandom_range(0, 1) == 1);
        else m_axi_awready = 0;
        if (w_hs) begin m_axi_wready = 0; w_got = 1; end
        else if (w_v) m_axi_wready = ($urandom_range(0, 1) == 1);
        else m_axi_wready = 0;
        if (b_hs) m_axi_bvalid = 0;
        if (aw_got && w_got) begin
          m_axi_bvalid = 1; m_axi_bresp = sl_bresp; aw_got = 0; w_got = 0;
        end
      end
    end
  end

  // Response monitor
  bit drop_pending = 0;
  always @(negedge clk) begin
    if (m_aresetn) begin
      drop_pending = 0;
    end else begin
      if (drop_pending) check("tx_valid_drop", 32'(tx_valid), 32'd0);
      drop_pending = tx_valid && tx_ready;
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte %h, expected no response", tx_data);
        end else begin
          check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
      end
    end
  end

  // Bus monitor
  always @(negedge clk) begin
    if (!m_aresetn) begin
      if (m_axi_arvalid && m_axi_arready) begin
        check("arsize", 32'(m_axi_arsize), 32'd2);
        if (exp_ar.size() == 0) begin
          checks++; errors++;
          $display("FAIL ar_unexpected: got araddr %h, expected no read", m_axi_araddr);
        end else check("araddr", m_axi_araddr, exp_ar.pop_front());
      end
      if (m_axi_awvalid && m_axi_awready) begin
        check("awsize", 32'(m_axi_awsize), 32'd2);
        if (exp_aw.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got awaddr %h, expected no write", m_axi_awaddr);
        end else check("awaddr", m_axi_awaddr, exp_aw.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        check("wstrb", 32'(m_axi_wstrb), 32'hF);
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got wdata %h, expected no write", m_axi_wdata);
        end else check("wdata", m_axi_wdata, exp_w.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 2000);
    check("idle_reached", 32'(rx_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 2000);
    check("rx_accept", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Issue one command; the model predicts the reply and any bus traffic.
  task automatic do_cmd(input logic [7:0] code, input logic [7:0] arg);
    int c;
    bit has_arg;
    c = int'(code);
    has_arg = 0;
    if (c >= 2 && c <= 5)        exp_tx.push_back(8'(gpi >> (8 * (c - 2))));
    else if (c >= 6 && c <= 9)   exp_tx.push_back(8'(m_gpo >> (8 * (c - 6))));
    else if (c >= 14 && c <= 17) exp_tx.push_back(8'(m_addr >> (8 * (c - 14))));
    else if (c == 22)            exp_tx.push_back(m_rdata[7:0]);
    else if (c == 24)            exp_tx.push_back(8'(m_bresp) * 8'd16 + 8'(m_rresp) * 8'd4);
    else if (c >= 10 && c <= 13) begin
      has_arg = 1;
      m_gpo = (m_gpo & ~(32'hFF << (8 * (c - 10)))) | (32'(arg) << (8 * (c - 10)));
    end else if (c >= 18 && c <= 21) begin
      has_arg = 1;
      m_addr = (m_addr & ~(32'hFF << (8 * (c - 18)))) | (32'(arg) << (8 * (c - 18)));
    end else if (c == 23) begin
      has_arg = 1;
      exp_aw.push_back(m_addr);
      exp_w.push_back(32'(arg));
      m_bresp = sl_bresp;
    end else if (c == 25) begin
      has_arg = 1;
      if (arg[1]) m_addr = m_addr + 32'd1;
      if (arg[0]) begin
        exp_ar.push_back(m_addr);
        m_rdata = sl_rdata;
        m_rresp = sl_rresp;
      end
    end
    send_byte(code);
    if (has_arg) send_byte(arg);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] code;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_gpo", gpo, 32'd0);
    check("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_rready", 32'(m_axi_rready), 32'd0);
    check("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst_bready", 32'(m_axi_bready), 32'd0);
    check("rst_araddr", m_axi_araddr, 32'd0);
    @(posedge clk); #1;
    m_aresetn = 1'b0;

    // GPI byte read: response the cycle after the command
    wait_ready();
    gpi = 32'hA1B2C3D4;
    do_cmd(8'd4, 8'd0);
    check("gpi_rd_tx_valid", 32'(tx_valid), 32'd1);
    check("gpi_rd_tx_data", 32'(tx_data), 32'hB2);

    // GPO byte 2 write and readback
    do_cmd(8'd12, 8'h5A);
    do_cmd(8'd8, 8'd0);
    wait_ready();
    check("gpo_byte2", gpo, 32'h005A_0000);

    // Address register assembly
    do_cmd(8'd18, 8'h10);
    do_cmd(8'd19, 8'h00);
    do_cmd(8'd20, 8'h00);
    do_cmd(8'd21, 8'h80);
    do_cmd(8'd17, 8'd0);
    wait_ready();
    check("araddr_assembled", m_axi_araddr, 32'h8000_0010);
    check("awaddr_assembled", m_axi_awaddr, 32'h8000_0010);

    // AXI write with SLVERR, then status byte
    wait_ready();
    sl_bresp = 2'b10;
    do_cmd(8'd23, 8'h3C);
    do_cmd(8'd24, 8'd0);

    // AXI read with delayed arready, then data and status bytes
    wait_ready();
    sl_rdata = 32'hDEADBEEF;
    sl_rresp = 2'b01;
    sl_ar_delay = 3;
    do_cmd(8'd25, 8'h01);
    do_cmd(8'd22, 8'd0);
    do_cmd(8'd24, 8'd0);

    // Address wrap via increment only
    sl_ar_delay = 0;
    do_cmd(8'd18, 8'hFF);
    do_cmd(8'd19, 8'hFF);
    do_cmd(8'd20, 8'hFF);
    do_cmd(8'd21, 8'hFF);
    do_cmd(8'd25, 8'h02);
    wait_ready();
    check("addr_wrap", m_axi_araddr, 32'd0);
    check("wrap_no_arvalid", 32'(m_axi_arvalid), 32'd0);

    // Unknown command is silently ignored
    do_cmd(8'd0, 8'd0);
    repeat (5) @(negedge clk);
    check("ignored_tx_valid", 32'(tx_valid), 32'd0);
    check("ignored_rx_ready", 32'(rx_ready), 32'd1);

    // Reset while the read address is outstanding
    wait_ready();
    sl_ar_delay = 40;
    do_cmd(8'd25, 8'h01);
    n = 0;
    while (!m_axi_arvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ar_before_rst", 32'(m_axi_arvalid), 32'd1);
    repeat (2) @(negedge clk);
    m_aresetn = 1'b1;
    #1;
    check("rst_mid_ar_arvalid", 32'(m_axi_arvalid), 32'd0);
    check("rst_mid_ar_rx_ready", 32'(rx_ready), 32'd0);
    exp_ar.delete();
    m_addr = 0; m_gpo = 0; m_rdata = 0; m_rresp = 0; m_bresp = 0;
    sl_ar_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    m_aresetn = 1'b0;
    wait_ready();
    check("post_rst_gpo", gpo, 32'd0);
    check("post_rst_addr", m_axi_araddr, 32'd0);

    // Randomized command stream
    for (int i = 0; i < 300; i++) begin
      wait_ready();
      gpi         = $urandom;
      sl_rdata    = $urandom;
      sl_rresp    = 2'($urandom_range(0, 3));
      sl_bresp    = 2'($urandom_range(0, 3));
      sl_ar_delay = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) code = 8'($urandom_range(0, 1));
        else code = 8'($urandom_range(26, 255));
      end else begin
        code = 8'($urandom_range(2, 25));
      end
      do_cmd(code, 8'($urandom));
    end

    wait_ready();
    repeat (10) @(negedge clk);
    check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    check("ar_queue_drained", 32'(exp_ar.size()), 32'd0);
    check("aw_queue_drained", 32'(exp_aw.size()), 32'd0);
    check("w_queue_drained", 32'(exp_w.size()), 32'd0);
    check("final_gpo", gpo, m_gpo);
    check("final_addr", m_axi_araddr, m_addr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
